l2_port_arbiter: RTL and testbench

Two-requester arbiter that shares one downstream cache/memory port between two upstream clients, normally the L1 instruction and L1 data caches in front of the L2 or main memory. It accepts read/write requests, grants one at a time by round-robin, forwards the request downstream with registered controls, waits for the downstream `ready`, and returns read data and a one-cycle `ready` pulse to the granted requester.

---
 rtl/l2_arb_pkg.sv | 19 +
 rtl/l2_port_arbiter_if.sv | 47 ++++
 rtl/l2_arb_pick.sv | 30 +++
 rtl/l2_port_arbiter.sv | 137 +++++++++++++
 tb/tb_l2_port_arbiter.sv | 303 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/l2_arb_pkg.sv
// Shared types for the L2 port arbiter: FSM states, requester ids and
// operation encoding.
package l2_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    localparam logic REQ0 = 1'b0;
    localparam logic REQ1 = 1'b1;

    typedef enum logic {
        OP_READ,
        OP_WRITE
    } op_t;

endpackage

// File: rtl/l2_port_arbiter_if.sv
// Bundle of requester-side and memory-side signals of the L2 port arbiter.
// The slave modport is the arbiter's view; master is the clients/memory view.
interface l2_port_arbiter_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) ();

    logic [ADDR_WIDTH-1:0] r0_addr;
    logic [DATA_WIDTH-1:0] r0_wdata;
    logic                  r0_read;
    logic                  r0_write;
    logic [DATA_WIDTH-1:0] r0_rdata;
    logic                  r0_ready;

    logic [ADDR_WIDTH-1:0] r1_addr;
    logic [DATA_WIDTH-1:0] r1_wdata;
    logic                  r1_read;
    logic                  r1_write;
    logic [DATA_WIDTH-1:0] r1_rdata;
    logic                  r1_ready;

    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_data_out;
    logic [DATA_WIDTH-1:0] mem_data_in;
    logic                  mem_read;
    logic                  mem_write;
    logic                  mem_ready;

    modport slave (
        input  r0_addr, r0_wdata, r0_read, r0_write,
        output r0_rdata, r0_ready,
        input  r1_addr, r1_wdata, r1_read, r1_write,
        output r1_rdata, r1_ready,
        output mem_addr, mem_data_out, mem_read, mem_write,
        input  mem_data_in, mem_ready
    );

    modport master (
        output r0_addr, r0_wdata, r0_read, r0_write,
        input  r0_rdata, r0_ready,
        output r1_addr, r1_wdata, r1_read, r1_write,
        input  r1_rdata, r1_ready,
        input  mem_addr, mem_data_out, mem_read, mem_write,
        output mem_data_in, mem_ready
    );

endinterface

// File: rtl/l2_arb_pick.sv
// Combinational winner selection for the two-requester arbiter.
// Optional macro L2_ARB_FIXED_PRIORITY_EN: requester 0 always wins a tie
// (last is then ignored); otherwise ties go to the requester that did not
// win most recently.
module l2_arb_pick
    import l2_arb_pkg::*;
(
    input  logic req0,
    input  logic req1,
    input  logic last,
    output logic grant,
    output logic win
);

    // Pick a winner among the active requesters.
    always_comb begin
        grant = req0 | req1;
        win   = REQ0;
        if (req0 && req1) begin
`ifdef L2_ARB_FIXED_PRIORITY_EN
            win = REQ0;
`else
            win = ~last;
`endif
        end else if (req1) begin
            win = REQ1;
        end
    end

endmodule

// File: rtl/l2_port_arbiter.sv
// Shares one downstream memory port between two upstream requesters.
// Requests are granted one at a time, forwarded with registered strobes,
// and completed with a one-cycle ready pulse plus captured read data.
// Optional macro L2_ARB_FIXED_PRIORITY_EN (applied in l2_arb_pick) selects
// fixed priority for requester 0 instead of round-robin.
module l2_port_arbiter
    import l2_arb_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) (
    input logic              clk,
    input logic              rst,
    l2_port_arbiter_if.slave bus
);

    state_t state;
    state_t state_next;

    logic                  last;
    logic                  win_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic                  mem_read_q;
    logic                  mem_write_q;
    logic                  r0_ready_q;
    logic                  r1_ready_q;
    logic [DATA_WIDTH-1:0] r0_rdata_q;
    logic [DATA_WIDTH-1:0] r1_rdata_q;

    logic req0;
    logic req1;
    logic grant;
    logic win;
    logic load;
    logic finish;
    op_t  op_sel;

    assign req0 = bus.r0_read | bus.r0_write;
    assign req1 = bus.r1_read | bus.r1_write;

    l2_arb_pick u_pick (
        .req0  (req0),
        .req1  (req1),
        .last  (last),
        .grant (grant),
        .win   (win)
    );

    // Write takes precedence when a requester raises read and write together.
    always_comb begin
        op_sel = OP_READ;
        if ((win == REQ1) ? bus.r1_write : bus.r0_write) begin
            op_sel = OP_WRITE;
        end
    end

    // Next-state logic and one-cycle load/finish strobes for the datapath.
    always_comb begin
        state_next = state;
        load       = 1'b0;
        finish     = 1'b0;
        unique case (state)
            IDLE: begin
                if (grant) begin
                    load       = 1'b1;
                    state_next = BUSY;
                end
            end
            BUSY: begin
                if (bus.mem_ready) begin
                    finish     = 1'b1;
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Request latching, downstream strobes, read data capture and ready pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            last        <= REQ1;
            win_q       <= REQ0;
            addr_q      <= '0;
            wdata_q     <= '0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            r0_ready_q  <= 1'b0;
            r1_ready_q  <= 1'b0;
            r0_rdata_q  <= '0;
            r1_rdata_q  <= '0;
        end else begin
            r0_ready_q <= 1'b0;
            r1_ready_q <= 1'b0;
            if (load) begin
                win_q       <= win;
                last        <= win;
                addr_q      <= (win == REQ1) ? bus.r1_addr : bus.r0_addr;
                wdata_q     <= (win == REQ1) ? bus.r1_wdata : bus.r0_wdata;
                mem_write_q <= (op_sel == OP_WRITE);
                mem_read_q  <= (op_sel == OP_READ);
            end
            if (finish) begin
                mem_read_q  <= 1'b0;
                mem_write_q <= 1'b0;
                if (win_q == REQ1) begin
                    r1_rdata_q <= bus.mem_data_in;
                    r1_ready_q <= 1'b1;
                end else begin
                    r0_rdata_q <= bus.mem_data_in;
                    r0_ready_q <= 1'b1;
                end
            end
        end
    end

    assign bus.mem_addr     = addr_q;
    assign bus.mem_data_out = wdata_q;
    assign bus.mem_read     = mem_read_q;
    assign bus.mem_write    = mem_write_q;
    assign bus.r0_ready     = r0_ready_q;
    assign bus.r1_ready     = r1_ready_q;
    assign bus.r0_rdata     = r0_rdata_q;
    assign bus.r1_rdata     = r1_rdata_q;

endmodule

// File: tb/tb_l2_port_arbiter.sv
// Self-checking bench for l2_port_arbiter: a directed vector table, a few
// hand-written multi-cycle sequences, and a randomized run checked every
// cycle against a transaction-level timing model.
module tb_l2_port_arbiter;

`ifdef L2_ARB_FIXED_PRIORITY_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    l2_port_arbiter_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus ();

    l2_port_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: one transaction in flight at most; timestamps in edges.
    int          cyc        = 0;
    int          free_at    = 0;
    int          pulse_edge = -1;
    bit          pulse_who  = 1'b0;
    bit          m_infl     = 1'b0;
    bit          m_win      = 1'b0;
    bit          m_wr       = 1'b0;
    bit          m_last     = 1'b1;
    logic [31:0] m_addr     = '0;
    logic [31:0] m_data     = '0;
    logic [31:0] rd_exp [2];

    // Bench control.
    bit          cont [2];
    bit          drop_pend [2];
    int          mem_mode   = 0;
    bit          rand_req   = 1'b0;
    bit          prev_strobe = 1'b0;
    logic [31:0] grants [$];

    typedef struct {
        logic        rd;
        logic [31:0] addr;
        logic        mrdy;
        logic [31:0] mdata;
        logic        e_mread;
        logic        e_r0rdy;
        logic        e_r1rdy;
        logic [31:0] e_r0data;
    } vec_t;
    vec_t tbl [7];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_req(input int i, input bit rd, input bit wr,
                           input logic [31:0] a, input logic [31:0] d);
        if (i == 0) begin
            bus.r0_read = rd; bus.r0_write = wr; bus.r0_addr = a; bus.r0_wdata = d;
        end else begin
            bus.r1_read = rd; bus.r1_write = wr; bus.r1_addr = a; bus.r1_wdata = d;
        end
    endtask

    function automatic bit active(input int i);
        return (i == 0) ? (bus.r0_read | bus.r0_write) : (bus.r1_read | bus.r1_write);
    endfunction

    // One clock: advance the model on the edge, check outputs, then drive.
    task automatic tick();
        bit q0, q1, w, strobe;
        bit rdy [2];
        bit just_dropped [2];
        @(posedge clk);
        cyc++;
        q0 = bus.r0_read | bus.r0_write;
        q1 = bus.r1_read | bus.r1_write;
        if (rst) begin
            m_infl = 1'b0; pulse_edge = -1; m_last = 1'b1;
            rd_exp[0] = '0; rd_exp[1] = '0; free_at = cyc + 1;
        end else if (m_infl) begin
            if (bus.mem_ready) begin
                rd_exp[m_win] = bus.mem_data_in;
                m_infl = 1'b0; pulse_edge = cyc; pulse_who = m_win; free_at = cyc + 2;
            end
        end else if (cyc >= free_at && (q0 || q1)) begin
            if (q0 && q1) w = FIXED ? 1'b0 : !m_last;
            else          w = q1;
            m_win = w; m_last = w; m_infl = 1'b1;
            m_wr   = w ? bus.r1_write : bus.r0_write;
            m_addr = w ? bus.r1_addr  : bus.r0_addr;
            m_data = w ? bus.r1_wdata : bus.r0_wdata;
        end
        #1;
        chk("mem_read",  bus.mem_read,  m_infl && !m_wr);
        chk("mem_write", bus.mem_write, m_infl && m_wr);
        if (m_infl) begin
            chk("mem_addr",     bus.mem_addr,     m_addr);
            chk("mem_data_out", bus.mem_data_out, m_data);
        end
        chk("r0_ready", bus.r0_ready, pulse_edge == cyc && !pulse_who);
        chk("r1_ready", bus.r1_ready, pulse_edge == cyc && pulse_who);
        chk("r0_rdata", bus.r0_rdata, rd_exp[0]);
        chk("r1_rdata", bus.r1_rdata, rd_exp[1]);

        strobe = bus.mem_read | bus.mem_write;
        if (strobe && !prev_strobe) grants.push_back(bus.mem_addr);
        prev_strobe = strobe;

        rdy[0] = bus.r0_ready;
        rdy[1] = bus.r1_ready;
        for (int i = 0; i < 2; i++) begin
            just_dropped[i] = 1'b0;
            if (drop_pend[i]) begin
                set_req(i, 1'b0, 1'b0, '0, '0);
                drop_pend[i] = 1'b0;
                just_dropped[i] = 1'b1;
            end
            if (rdy[i] && !cont[i]) drop_pend[i] = 1'b1;
            if (rand_req && !drop_pend[i] && !just_dropped[i] && !active(i)
                && $urandom_range(0, 3) == 0) begin
                case ($urandom_range(0, 2))
                    0:       set_req(i, 1'b1, 1'b0, $urandom, $urandom);
                    1:       set_req(i, 1'b0, 1'b1, $urandom, $urandom);
                    default: set_req(i, 1'b1, 1'b1, $urandom, $urandom);
                endcase
            end
        end

        if (mem_mode > 0) begin
            bus.mem_data_in = $urandom;
            if (strobe) bus.mem_ready = ($urandom_range(0, 2) == 0);
            else        bus.mem_ready = (mem_mode == 2) && ($urandom_range(0, 3) == 0);
        end
    endtask

    task automatic do_reset();
        set_req(0, 1'b0, 1'b0, '0, '0);
        set_req(1, 1'b0, 1'b0, '0, '0);
        cont[0] = 1'b0; cont[1] = 1'b0;
        drop_pend[0] = 1'b0; drop_pend[1] = 1'b0;
        bus.mem_ready = 1'b0;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        int pulses;
        bit saw_r, saw_w, got, first_read;
        logic [31:0] w_addr, w_data;

        set_req(0, 1'b0, 1'b0, '0, '0);
        set_req(1, 1'b0, 1'b0, '0, '0);
        bus.mem_ready = 1'b0;
        bus.mem_data_in = '0;

        tbl[0] = '{1'b1, 32'h100, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 32'h0};
        tbl[1] = '{1'b1, 32'h100, 1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 32'h0};
        tbl[2] = '{1'b1, 32'h100, 1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 32'h0};
        tbl[3] = '{1'b1, 32'h100, 1'b1, 32'hDEADBEEF, 1'b1, 1'b0, 1'b0, 32'h0};
        tbl[4] = '{1'b1, 32'h100, 1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 32'hDEADBEEF};
        tbl[5] = '{1'b0, 32'h0,   1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 32'hDEADBEEF};
        tbl[6] = '{1'b0, 32'h0,   1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 32'hDEADBEEF};

        // Reset state.
        do_reset();
        chk("rst_mem_read",  bus.mem_read,  1'b0);
        chk("rst_mem_write", bus.mem_write, 1'b0);
        chk("rst_mem_addr",  bus.mem_addr,  32'h0);
        chk("rst_r0_ready",  bus.r0_ready,  1'b0);
        chk("rst_r1_ready",  bus.r1_ready,  1'b0);
        chk("rst_r0_rdata",  bus.r0_rdata,  32'h0);
        chk("rst_r1_rdata",  bus.r1_rdata,  32'h0);

        // Single read, cycle by cycle.
        mem_mode = 0;
        for (int i = 0; i < 7; i++) begin
            chk($sformatf("tbl%0d_mem_read", i), bus.mem_read, tbl[i].e_mread);
            chk($sformatf("tbl%0d_r0_ready", i), bus.r0_ready, tbl[i].e_r0rdy);
            chk($sformatf("tbl%0d_r1_ready", i), bus.r1_ready, tbl[i].e_r1rdy);
            chk($sformatf("tbl%0d_r0_rdata", i), bus.r0_rdata, tbl[i].e_r0data);
            if (tbl[i].e_mread) chk($sformatf("tbl%0d_mem_addr", i), bus.mem_addr, 32'h100);
            bus.r0_read     = tbl[i].rd;
            bus.r0_addr     = tbl[i].addr;
            bus.mem_ready   = tbl[i].mrdy;
            bus.mem_data_in = tbl[i].mdata;
            tick();
        end

        // Tie right after reset: requester 0 first, then requester 1's write.
        do_reset();
        mem_mode = 1;
        grants.delete();
        set_req(0, 1'b1, 1'b0, 32'h200, 32'h0);
        set_req(1, 1'b0, 1'b1, 32'h300, 32'h12345678);
        got = 1'b0; saw_w = 1'b0; first_read = 1'b0; w_addr = '0; w_data = '0;
        for (int n = 0; n < 100 && !got; n++) begin
            tick();
            if (grants.size() == 1 && (bus.mem_read | bus.mem_write) && n < 3)
                first_read = bus.mem_read;
            if (bus.mem_write && !saw_w) begin
                saw_w = 1'b1; w_addr = bus.mem_addr; w_data = bus.mem_data_out;
            end
            if (bus.r1_ready) got = 1'b1;
        end
        chk("tie_r1_ready_seen", got, 1'b1);
        chk("tie_grant_count", grants.size(), 2);
        if (grants.size() >= 1) chk("tie_first_addr", grants[0], 32'h200);
        chk("tie_first_is_read", first_read, 1'b1);
        chk("tie_write_seen", saw_w, 1'b1);
        chk("tie_write_addr", w_addr, 32'h300);
        chk("tie_write_data", w_data, 32'h12345678);

        // Fairness with both requesters asserting continuously.
        do_reset();
        mem_mode = 1;
        cont[0] = 1'b1; cont[1] = 1'b1;
        grants.delete();
        set_req(0, 1'b1, 1'b0, 32'h1000, 32'h0);
        set_req(1, 1'b1, 1'b0, 32'h2000, 32'h0);
        for (int n = 0; n < 300 && grants.size() < 6; n++) tick();
        chk("fair_grant_count", grants.size() >= 6, 1'b1);
        for (int k = 0; k < 6 && k < grants.size(); k++)
            chk($sformatf("fair_grant%0d", k), grants[k],
                (FIXED || k % 2 == 0) ? 32'h1000 : 32'h2000);

        // Read and write together from requester 1.
        do_reset();
        mem_mode = 1;
        set_req(1, 1'b1, 1'b1, 32'h440, 32'hA5A50F0F);
        pulses = 0; saw_r = 1'b0; saw_w = 1'b0;
        for (int n = 0; n < 100 && pulses == 0; n++) begin
            tick();
            saw_r |= bus.mem_read;
            saw_w |= bus.mem_write;
            if (bus.r1_ready) pulses++;
        end
        repeat (4) begin
            tick();
            saw_r |= bus.mem_read;
            if (bus.r1_ready) pulses++;
        end
        chk("rw_no_mem_read", saw_r, 1'b0);
        chk("rw_write_seen", saw_w, 1'b1);
        chk("rw_r1_pulses", pulses, 1);

        // Reset while busy abandons the transaction.
        do_reset();
        mem_mode = 0;
        bus.mem_ready = 1'b0;
        set_req(0, 1'b1, 1'b0, 32'h700, 32'h0);
        for (int n = 0; n < 10 && !bus.mem_read; n++) tick();
        chk("rstmid_busy", bus.mem_read, 1'b1);
        rst = 1'b1;
        set_req(0, 1'b0, 1'b0, '0, '0);
        tick();
        rst = 1'b0;
        chk("rstmid_mem_read",  bus.mem_read,  1'b0);
        chk("rstmid_mem_write", bus.mem_write, 1'b0);
        chk("rstmid_mem_addr",  bus.mem_addr,  32'h0);
        chk("rstmid_r0_ready",  bus.r0_ready,  1'b0);
        chk("rstmid_r1_ready",  bus.r1_ready,  1'b0);
        pulses = 0;
        repeat (4) begin
            tick();
            if (bus.r0_ready | bus.r1_ready) pulses++;
        end
        chk("rstmid_no_pulse", pulses, 0);
        mem_mode = 1;
        set_req(1, 1'b1, 1'b0, 32'h900, 32'h0);
        got = 1'b0;
        for (int n = 0; n < 60 && !got; n++) begin
            tick();
            if (bus.r1_ready) got = 1'b1;
        end
        chk("rstmid_r1_served", got, 1'b1);

        // Randomized traffic with spurious mem_ready outside transactions.
        do_reset();
        mem_mode = 2;
        rand_req = 1'b1;
        repeat (3000) tick();
        rand_req = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
